// File: rtl/even_parity_frame_tx_pkg.sv
// Shared definitions for the even-parity serial frame transmitter:
// FSM state encoding and the fixed line levels of a frame.
package even_parity_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic TX_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/even_parity_frame_tx_parity.sv
// Even-parity generator: output is the XOR of all data bits, so data plus
// parity always carries an even number of ones.
module even_parity_frame_tx_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_in,
  output logic             parity
);

  logic [WIDTH:0] chain;

  assign chain[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_xor
      assign chain[gi+1] = chain[gi] ^ data_in[gi];
    end
  endgenerate

  assign parity = chain[WIDTH];

endmodule

// File: rtl/even_parity_frame_tx.sv
// Serial frame transmitter: accepts a byte on valid/ready and sends
// start(0), data LSB-first, even parity, stop(1), each held CLKS_PER_BIT clocks.
module even_parity_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  import even_parity_frame_tx_pkg::*;

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);

  tx_state_e         state_reg, state_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              par_q_reg, par_q_next;
  logic              tx_reg, tx_next;
  logic              frame_done_reg, frame_done_next;
  logic              parity_bit;
  logic              bit_tick;

  even_parity_frame_tx_parity #(
    .WIDTH (DATA_W)
  ) u_parity (
    .data_in (in_data),
    .parity  (parity_bit)
  );

  assign bit_tick = (timer_reg == TIMER_LAST);

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    par_q_next   = par_q_reg;

    if (state_reg != IDLE) begin
      timer_next = bit_tick ? '0 : timer_reg + TW'(1);
    end

    case (state_reg)
      IDLE: begin
        timer_next   = '0;
        bit_cnt_next = '0;
        if (in_valid) begin
          state_next = START;
          shift_next = in_data;
          par_q_next = parity_bit;
        end
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next   = PARITY;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
      STOP: begin
        if (bit_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // tx and frame_done are registered, so they are decoded from the next state
  // to line up with the cycle that state is actually occupied.
  always_comb begin
    tx_next = TX_IDLE;
    case (state_next)
      IDLE:    tx_next = TX_IDLE;
      START:   tx_next = START_BIT;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_q_next;
      STOP:    tx_next = STOP_BIT;
      default: tx_next = TX_IDLE;
    endcase
    frame_done_next = (state_next == STOP) && (timer_next == TIMER_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_q_reg      <= 1'b0;
      tx_reg         <= TX_IDLE;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      par_q_reg      <= par_q_next;
      tx_reg         <= tx_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign tx         = tx_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_even_parity_frame_tx.sv
// Self-checking bench: directed and random frames decoded from tx and compared
// against a frame built directly from the byte sent.
module tb_even_parity_frame_tx;

  localparam int CPB   = 4;
  localparam int DW    = 8;
  localparam int FRAME = (DW + 3) * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic          frame_done;

  int errors = 0;
  int checks = 0;
  int frame_no = 0;

  even_parity_frame_tx #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present a byte and wait (bounded) for the accepting edge; returns with
  // time just after that edge, i.e. inside the first START cycle.
  task automatic do_handshake(input logic [DW-1:0] d, input bit keep_valid, output int waited);
    bit ok;
    ok       = 1'b0;
    waited   = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!ok && waited < 300) begin
      @(negedge clk);
      waited++;
      if (in_ready === 1'b1) ok = 1'b1;
    end
    check_eq("handshake_ready", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Sample every cycle of one frame and compare against the ideal frame.
  task automatic capture_frame(input logic [DW-1:0] d, input bit poke, output logic [10:0] dec);
    logic [FRAME-1:0] samp;
    logic [10:0]      exp_frame;
    int fd_cnt, fd_pos, busy_cnt, bad, idx;
    fd_cnt = 0; fd_pos = -1; busy_cnt = 0; bad = 0;
    exp_frame = {1'b1, ^d, d, 1'b0};
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      samp[c] = tx;
      if (frame_done === 1'b1) begin fd_cnt++; fd_pos = c; end
      if (busy === 1'b1) busy_cnt++;
      if (poke && c == 20) begin in_valid = 1'b1; in_data = 8'h55; end
      if (poke && c == 22) begin in_valid = 1'b0; in_data = ~d; end
    end
    for (int c = 0; c < FRAME; c++) begin
      idx = c / CPB;
      if (samp[c] !== exp_frame[idx]) bad++;
    end
    for (int k = 0; k < 11; k++) dec[k] = samp[k*CPB + CPB/2];
    frame_no++;
    $display("frame %0d data=0x%02h decoded=0x%03h parity=%0b fd_pos=%0d poke=%0b",
             frame_no, d, dec, dec[9], fd_pos, poke);
    check_eq("frame_bits", 32'(dec), 32'(exp_frame));
    check_eq("start_bit", 32'(dec[0]), 32'd0);
    check_eq("stop_bit", 32'(dec[10]), 32'd1);
    check_eq("data_bits", 32'(dec[8:1]), 32'(d));
    check_eq("even_ones", 32'($countones(dec[9:1]) % 2), 32'd0);
    check_eq("bit_hold", 32'(bad), 32'd0);
    check_eq("busy_cycles", 32'(busy_cnt), 32'(FRAME));
    check_eq("frame_done_cnt", 32'(fd_cnt), 32'd1);
    check_eq("frame_done_pos", 32'(fd_pos), 32'(FRAME - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] dec;
    int w, cnt_busy, cnt_fd;
    logic [DW-1:0] d;

    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // 0x03: start, 1,1,0..0, parity 0, stop
    do_handshake(8'h03, 1'b0, w);
    capture_frame(8'h03, 1'b0, dec);
    check_eq("t1_vector", 32'(dec), 32'(11'b10000000110));
    @(negedge clk);
    check_eq("t1_ready_after", 32'(in_ready), 32'd1);
    check_eq("t1_busy_after", 32'(busy), 32'd0);
    check_eq("t1_tx_idle", 32'(tx), 32'd1);

    do_handshake(8'hDA, 1'b0, w);
    capture_frame(8'hDA, 1'b0, dec);
    check_eq("t2_da_vector", 32'(dec), 32'(11'b11110110100));
    do_handshake(8'hAA, 1'b0, w);
    capture_frame(8'hAA, 1'b0, dec);
    check_eq("t2_aa_parity", 32'(dec[9]), 32'd0);

    // Back-to-back with in_valid held high throughout
    do_handshake(8'h00, 1'b1, w);
    in_data = 8'hFF;
    capture_frame(8'h00, 1'b0, dec);
    check_eq("t3_00_parity", 32'(dec[9]), 32'd0);
    do_handshake(8'hFF, 1'b0, w);
    check_eq("t3_idle_gap", 32'(w), 32'd1);
    capture_frame(8'hFF, 1'b0, dec);
    check_eq("t3_ff_parity", 32'(dec[9]), 32'd0);

    // in_valid pulse while busy must be ignored
    do_handshake(8'h3C, 1'b0, w);
    capture_frame(8'h3C, 1'b1, dec);
    cnt_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) cnt_busy++;
    end
    check_eq("t4_no_extra_frame", 32'(cnt_busy), 32'd0);

    // Reset in the middle of DATA
    do_handshake(8'hDA, 1'b0, w);
    repeat (16) @(negedge clk);
    check_eq("t5_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t5_tx", 32'(tx), 32'd1);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_in_ready", 32'(in_ready), 32'd1);
    check_eq("t5_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    cnt_busy = 0; cnt_fd = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy !== 1'b0) cnt_busy++;
      if (frame_done !== 1'b0) cnt_fd++;
    end
    check_eq("t5_no_frame_done", 32'(cnt_fd), 32'd0);
    check_eq("t5_stays_idle", 32'(cnt_busy), 32'd0);

    // Random bytes, random gaps, random in-flight pokes
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_handshake(d, 1'b0, w);
      capture_frame(d, 1'($urandom_range(0, 1)), dec);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
